// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter that multiplexes NUM_CH cache clients onto one DDR burst port,
// with burst-length clamping, a zero-length fast path and a per-burst watchdog.
module ddr_burst_arbiter #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DDR_DATA_WIDTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned CH_DATA_WIDTH  = 32,
    parameter int unsigned MAX_BURST      = 64,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                               mem_clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  ch_req,
    input  logic [NUM_CH-1:0]                  ch_we,
    input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*10-1:0]               ch_len,
    input  logic [NUM_CH*CH_DATA_WIDTH-1:0]    ch_wdata,
    output logic [NUM_CH-1:0]                  ch_grant,
    output logic [NUM_CH-1:0]                  ch_wdata_req,
    output logic [CH_DATA_WIDTH-1:0]           ch_rdata,
    output logic [NUM_CH-1:0]                  ch_rvalid,
    output logic [NUM_CH-1:0]                  ch_done,
    output logic [NUM_CH-1:0]                  ch_err,
    output logic                               rd_burst_req,
    output logic                               wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
    output logic [9:0]                         rd_burst_len,
    output logic [9:0]                         wr_burst_len,
    output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data,
    input  logic [DDR_DATA_WIDTH-1:0]          rd_burst_data,
    input  logic                               rd_burst_data_valid,
    input  logic                               wr_burst_data_req,
    input  logic                               rd_burst_finish,
    input  logic                               wr_burst_finish
);

    localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [9:0] MAX_LEN = 10'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_BURST,
        S_WR_BURST,
        S_DONE,
        S_ABORT
    } state_t;

    state_t                     state_q;
    logic [ID_W-1:0]            id_q;
    logic [ID_W-1:0]            last_q;
    logic                       we_q;
    logic [DDR_ADDR_WIDTH-1:0]  addr_q;
    logic [9:0]                 len_q;
    logic [9:0]                 beat_q;
    logic [WD_W-1:0]            wd_q;
    logic                       rd_req_q;
    logic                       wr_req_q;
    logic [NUM_CH-1:0]          grant_q;
    logic [NUM_CH-1:0]          rvalid_q;
    logic [NUM_CH-1:0]          done_q;
    logic [NUM_CH-1:0]          err_q;
    logic [CH_DATA_WIDTH-1:0]   rdata_q;

    logic                       arb_valid;
    logic [ID_W-1:0]            arb_id;
    logic [9:0]                 arb_len_raw;
    logic [9:0]                 arb_len_d;
    int unsigned                arb_idx;

    // Search starts one past the last served channel and wraps.
    always_comb begin
        arb_valid = 1'b0;
        arb_id    = '0;
        arb_idx   = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            arb_idx = (32'(last_q) + i) % NUM_CH;
            if (!arb_valid && ch_req[ID_W'(arb_idx)]) begin
                arb_valid = 1'b1;
                arb_id    = ID_W'(arb_idx);
            end
        end
    end

    always_comb begin
        arb_len_raw = ch_len[arb_id*10 +: 10];
        arb_len_d   = (arb_len_raw > MAX_LEN) ? MAX_LEN : arb_len_raw;
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            last_q   <= ID_W'(NUM_CH - 1);
            we_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            wd_q     <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            grant_q  <= '0;
            rvalid_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            grant_q  <= '0;
            rvalid_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        id_q            <= arb_id;
                        we_q            <= ch_we[arb_id];
                        addr_q          <= ch_addr[arb_id*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
                        len_q           <= arb_len_d;
                        beat_q          <= '0;
                        wd_q            <= '0;
                        grant_q[arb_id] <= 1'b1;
                        if (arb_len_d == '0) begin
                            state_q <= S_DONE;
                        end else if (ch_we[arb_id]) begin
                            state_q  <= S_WR_BURST;
                            wr_req_q <= 1'b1;
                        end else begin
                            state_q  <= S_RD_BURST;
                            rd_req_q <= 1'b1;
                        end
                    end
                end
                S_RD_BURST: begin
                    if (rd_burst_data_valid) begin
                        rdata_q        <= rd_burst_data[CH_DATA_WIDTH-1:0];
                        rvalid_q[id_q] <= 1'b1;
                        beat_q         <= beat_q + 10'd1;
                    end
                    if (rd_burst_finish) begin
                        state_q      <= S_DONE;
                        rd_req_q     <= 1'b0;
                        done_q[id_q] <= 1'b1;
                    end else if (rd_burst_data_valid) begin
                        wd_q <= '0;
                    end else if (wd_q == WD_LAST) begin
                        state_q     <= S_ABORT;
                        rd_req_q    <= 1'b0;
                        err_q[id_q] <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_WR_BURST: begin
                    if (wr_burst_data_req) begin
                        beat_q <= beat_q + 10'd1;
                    end
                    if (wr_burst_finish) begin
                        state_q      <= S_DONE;
                        wr_req_q     <= 1'b0;
                        done_q[id_q] <= 1'b1;
                    end else if (wr_burst_data_req) begin
                        wd_q <= '0;
                    end else if (wd_q == WD_LAST) begin
                        state_q     <= S_ABORT;
                        wr_req_q    <= 1'b0;
                        err_q[id_q] <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // A burst already pulsed done on its finish edge; the zero-length path pulses here.
                    if (len_q == '0) begin
                        done_q[id_q] <= 1'b1;
                    end
                    last_q  <= id_q;
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    rd_req_q <= 1'b0;
                    wr_req_q <= 1'b0;
                    last_q   <= id_q;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ch_wdata_req  = '0;
        wr_burst_data = '0;
        if (state_q == S_WR_BURST) begin
            ch_wdata_req[id_q]                = wr_burst_data_req;
            wr_burst_data[CH_DATA_WIDTH-1:0]  = ch_wdata[id_q*CH_DATA_WIDTH +: CH_DATA_WIDTH];
        end
    end

    assign ch_grant      = grant_q;
    assign ch_rvalid     = rvalid_q;
    assign ch_rdata      = rdata_q;
    assign ch_done       = done_q;
    assign ch_err        = err_q;
    assign rd_burst_req  = rd_req_q;
    assign wr_burst_req  = wr_req_q;
    assign rd_burst_addr = addr_q;
    assign wr_burst_addr = addr_q;
    assign rd_burst_len  = len_q;
    assign wr_burst_len  = len_q;

    // Upper read-data lanes, the latched direction and the beat count are not consumed downstream.
    logic unused_sigs;
    assign unused_sigs = ^{rd_burst_data, we_q, beat_q};

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Scoreboard bench for ddr_burst_arbiter: read beats are queued when driven and
// checked when ch_rvalid appears; grants, strobes and pulses are checked inline.
module tb_ddr_burst_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 128;
    localparam int unsigned AW  = 28;
    localparam int unsigned CW  = 32;
    localparam int unsigned MB  = 64;
    localparam int unsigned TO  = 16;

    logic                 mem_clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       ch_req;
    logic [NCH-1:0]       ch_we;
    logic [NCH*AW-1:0]    ch_addr;
    logic [NCH*10-1:0]    ch_len;
    logic [NCH*CW-1:0]    ch_wdata;
    logic [NCH-1:0]       ch_grant;
    logic [NCH-1:0]       ch_wdata_req;
    logic [CW-1:0]        ch_rdata;
    logic [NCH-1:0]       ch_rvalid;
    logic [NCH-1:0]       ch_done;
    logic [NCH-1:0]       ch_err;
    logic                 rd_burst_req;
    logic                 wr_burst_req;
    logic [AW-1:0]        rd_burst_addr;
    logic [AW-1:0]        wr_burst_addr;
    logic [9:0]           rd_burst_len;
    logic [9:0]           wr_burst_len;
    logic [DW-1:0]        wr_burst_data;
    logic [DW-1:0]        rd_burst_data;
    logic                 rd_burst_data_valid;
    logic                 wr_burst_data_req;
    logic                 rd_burst_finish;
    logic                 wr_burst_finish;

    ddr_burst_arbiter #(
        .NUM_CH         (NCH),
        .DDR_DATA_WIDTH (DW),
        .DDR_ADDR_WIDTH (AW),
        .CH_DATA_WIDTH  (CW),
        .MAX_BURST      (MB),
        .TIMEOUT        (TO)
    ) dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .ch_req              (ch_req),
        .ch_we               (ch_we),
        .ch_addr             (ch_addr),
        .ch_len              (ch_len),
        .ch_wdata            (ch_wdata),
        .ch_grant            (ch_grant),
        .ch_wdata_req        (ch_wdata_req),
        .ch_rdata            (ch_rdata),
        .ch_rvalid           (ch_rvalid),
        .ch_done             (ch_done),
        .ch_err              (ch_err),
        .rd_burst_req        (rd_burst_req),
        .wr_burst_req        (wr_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .wr_burst_addr       (wr_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data       (wr_burst_data),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_data_valid (rd_burst_data_valid),
        .wr_burst_data_req   (wr_burst_data_req),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_finish     (wr_burst_finish)
    );

    always #5 mem_clk = ~mem_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    logic any_out;
    assign any_out = |{ch_grant, ch_wdata_req, ch_rdata, ch_rvalid, ch_done, ch_err,
                       rd_burst_req, wr_burst_req, rd_burst_addr, wr_burst_addr,
                       rd_burst_len, wr_burst_len, wr_burst_data};

    // Scoreboard: {expected channel mask, expected data} per driven read beat.
    logic [NCH-1:0] act_mask;
    logic [35:0]    sb_q[$];
    int             rvalid_seen = 0;
    int             done_cnt[NCH];
    int             err_cnt[NCH];

    initial begin
        for (int i = 0; i < NCH; i++) begin
            done_cnt[i] = 0;
            err_cnt[i]  = 0;
        end
    end

    always @(posedge mem_clk) begin
        if (!rst && rd_burst_data_valid) sb_q.push_back({act_mask, rd_burst_data[CW-1:0]});
    end

    always @(negedge mem_clk) begin
        logic [35:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rvalid", 128'(ch_rvalid), 128'(e[35:32]));
            check("rdata", 128'(ch_rdata), 128'(e[31:0]));
            rvalid_seen++;
        end else if (ch_rvalid != '0) begin
            check("rvalid_spurious", 128'(ch_rvalid), 128'(0));
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch_done[i]) done_cnt[i]++;
            if (ch_err[i])  err_cnt[i]++;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no_finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0, r0, e0, since, waited, lat, strobes;
        logic [CW-1:0] w;
        rst = 1'b1;
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_len = '0; ch_wdata = '0;
        rd_burst_data = '0; rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
        rd_burst_finish = 1'b0; wr_burst_finish = 1'b0; act_mask = '0;
        repeat (3) tick();
        check("reset_outs", 128'(any_out), 128'(0));
        rst = 1'b0;
        tick();
        check("idle_outs", 128'(any_out), 128'(0));

        // Channel 1 read, 16 beats
        ch_we = '0;
        ch_addr[1*AW +: AW] = 28'h0008000;
        ch_len[1*10 +: 10]  = 10'd16;
        ch_req   = 4'b0010;
        act_mask = 4'b0010;
        d0 = done_cnt[1];
        r0 = rvalid_seen;
        tick();
        check("rd_grant", 128'(ch_grant), 128'(4'b0010));
        check("rd_req", 128'(rd_burst_req), 128'(1));
        check("rd_wr_req_low", 128'(wr_burst_req), 128'(0));
        check("rd_addr", 128'(rd_burst_addr), 128'(28'h0008000));
        check("rd_len", 128'(rd_burst_len), 128'(16));
        ch_req = '0;
        for (int i = 0; i < 16; i++) begin
            if (i % 5 == 3) begin
                rd_burst_data_valid = 1'b0;
                tick();
            end
            rd_burst_data_valid = 1'b1;
            rd_burst_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rd_burst_data_valid = 1'b0;
        rd_burst_finish = 1'b1;
        tick();
        check("rd_done", 128'(ch_done), 128'(4'b0010));
        check("rd_req_drop", 128'(rd_burst_req), 128'(0));
        rd_burst_finish = 1'b0;
        tick();
        check("rd_done_pulse", 128'(ch_done), 128'(0));
        check("rd_beats", 128'(rvalid_seen - r0), 128'(16));
        check("rd_done_once", 128'(done_cnt[1] - d0), 128'(1));

        // Round robin after reset: 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_len = {4{10'd1}};
        ch_we  = '0;
        ch_req = 4'b1111;
        since  = 0;
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            while (ch_grant == '0 && waited < 10) begin
                tick();
                waited++;
                since++;
            end
            act_mask = 4'b0001 << (n % 4);
            check("rr_grant", 128'(ch_grant), 128'(act_mask));
            if (n > 0) check("rr_gap", 128'(since), 128'(3));
            if (n == 4) ch_req = '0;
            rd_burst_data_valid = 1'b1;
            rd_burst_data = {$urandom, $urandom, $urandom, $urandom};
            rd_burst_finish = 1'b1;
            tick();
            since = 1;
            rd_burst_data_valid = 1'b0;
            rd_burst_finish = 1'b0;
        end
        tick();

        // Channel 2 write, len 200 clamped to 64
        ch_we = 4'b0100;
        ch_len[2*10 +: 10]  = 10'd200;
        ch_addr[2*AW +: AW] = 28'h0ABCDE0;
        ch_req = 4'b0100;
        d0 = done_cnt[2];
        tick();
        check("wr_grant", 128'(ch_grant), 128'(4'b0100));
        check("wr_req", 128'(wr_burst_req), 128'(1));
        check("wr_rd_req_low", 128'(rd_burst_req), 128'(0));
        check("wr_len_clamp", 128'(wr_burst_len), 128'(64));
        check("wr_addr", 128'(wr_burst_addr), 128'(28'h0ABCDE0));
        ch_req = '0;
        strobes = 0;
        for (int i = 0; i < 64; i++) begin
            rd_burst_finish = 1'b0;
            if (i % 7 == 2) begin
                wr_burst_data_req = 1'b0;
                #1;
                check("wdreq_gap", 128'(ch_wdata_req), 128'(0));
                tick();
            end
            w = $urandom;
            ch_wdata[2*CW +: CW] = w;
            wr_burst_data_req = 1'b1;
            rd_burst_finish = (i == 10);
            #1;
            check("wdata_req", 128'(ch_wdata_req), 128'(4'b0100));
            check("wdata", 128'(wr_burst_data), {96'd0, w});
            if (ch_wdata_req[2]) strobes++;
            tick();
        end
        wr_burst_data_req = 1'b0;
        rd_burst_finish = 1'b0;
        check("wr_ignores_rd_finish", 128'(wr_burst_req), 128'(1));
        check("wr_strobes", 128'(strobes), 128'(64));
        wr_burst_finish = 1'b1;
        tick();
        check("wr_done", 128'(ch_done), 128'(4'b0100));
        check("wr_req_drop", 128'(wr_burst_req), 128'(0));
        check("wr_data_idle", 128'(wr_burst_data), 128'(0));
        wr_burst_finish = 1'b0;
        tick();
        check("wr_done_once", 128'(done_cnt[2] - d0), 128'(1));

        // Zero-length on channel 3
        ch_we = '0;
        ch_len[3*10 +: 10] = 10'd0;
        ch_req = 4'b1000;
        d0 = done_cnt[3];
        tick();
        check("zl_grant", 128'(ch_grant), 128'(4'b1000));
        check("zl_no_req_c1", 128'({rd_burst_req, wr_burst_req}), 128'(0));
        check("zl_no_done_c1", 128'(ch_done), 128'(0));
        ch_req = '0;
        tick();
        check("zl_done", 128'(ch_done), 128'(4'b1000));
        check("zl_no_req_c2", 128'({rd_burst_req, wr_burst_req}), 128'(0));
        tick();
        check("zl_done_once", 128'(done_cnt[3] - d0), 128'(1));

        // Watchdog: channel 0 read, controller silent
        ch_len[0 +: 10] = 10'd4;
        ch_req = 4'b0001;
        e0 = err_cnt[0];
        d0 = done_cnt[0];
        tick();
        check("wd_grant", 128'(ch_grant), 128'(4'b0001));
        check("wd_req", 128'(rd_burst_req), 128'(1));
        ch_req = '0;
        lat = 0;
        while (ch_err == '0 && lat < 40) begin
            tick();
            lat++;
        end
        check("wd_err", 128'(ch_err), 128'(4'b0001));
        check("wd_latency", 128'(lat), 128'(16));
        check("wd_req_drop", 128'(rd_burst_req), 128'(0));
        check("wd_no_done", 128'(ch_done), 128'(0));
        tick();
        check("wd_err_once", 128'(err_cnt[0] - e0), 128'(1));
        check("wd_no_done_cnt", 128'(done_cnt[0] - d0), 128'(0));
        ch_len[0 +: 10] = 10'd2;
        ch_req = 4'b0001;
        act_mask = 4'b0001;
        tick();
        check("wd_next_grant", 128'(ch_grant), 128'(4'b0001));
        check("wd_next_req", 128'(rd_burst_req), 128'(1));
        ch_req = '0;
        for (int i = 0; i < 2; i++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rd_burst_data_valid = 1'b0;
        rd_burst_finish = 1'b1;
        tick();
        check("wd_next_done", 128'(ch_done), 128'(4'b0001));
        rd_burst_finish = 1'b0;
        tick();

        // Reset in the middle of a channel 1 write
        ch_we = 4'b0010;
        ch_len[1*10 +: 10] = 10'd8;
        ch_req = 4'b0010;
        tick();
        check("rw_grant", 128'(ch_grant), 128'(4'b0010));
        check("rw_req", 128'(wr_burst_req), 128'(1));
        ch_req = '0;
        d0 = done_cnt[1];
        e0 = err_cnt[1];
        for (int i = 0; i < 3; i++) begin
            ch_wdata[1*CW +: CW] = $urandom;
            wr_burst_data_req = 1'b1;
            tick();
        end
        wr_burst_data_req = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_mid_outs", 128'(any_out), 128'(0));
        rst = 1'b0;
        ch_we  = '0;
        ch_len = {4{10'd1}};
        ch_req = 4'b1111;
        tick();
        check("rst_last_grant", 128'(ch_grant), 128'(4'b0001));
        check("rst_rd_req", 128'(rd_burst_req), 128'(1));
        ch_req = '0;
        act_mask = 4'b0001;
        rd_burst_data_valid = 1'b1;
        rd_burst_data = {$urandom, $urandom, $urandom, $urandom};
        rd_burst_finish = 1'b1;
        tick();
        rd_burst_data_valid = 1'b0;
        rd_burst_finish = 1'b0;
        tick();
        tick();
        check("rst_no_done", 128'(done_cnt[1] - d0), 128'(0));
        check("rst_no_err", 128'(err_cnt[1] - e0), 128'(0));
        check("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
